// File: rtl/adder_result_accum.sv
// Accumulates COUNT adder results {cout,sum} per batch into a wrapping ACC_W-bit sum with a sticky overflow flag.
// Latency: one cycle per accepted sample; done pulses the cycle after sample COUNT. No backpressure: in_valid gaps stall the batch.
// Optional ACCUM_MAX_TRACK_EN tracks the largest sample in max_val; when undefined, max_val is tied to 0.
module adder_result_accum #(
    parameter int N     = 4,
    parameter int COUNT = 8,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [N-1:0]     sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic [7:0]       sample_cnt,
    output logic             ovf,
    output logic [N:0]       max_val
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N:0]       sample;
    logic [ACC_W:0]   acc_sum;
    logic             accept;
    logic             clear;
    logic             last;

    assign sample  = {cout, sum};
    assign acc_sum = {1'b0, acc} + {{(ACC_W - N){1'b0}}, sample};
    assign accept  = (state == ACCUM) && in_valid;
    assign clear   = start && ((state == IDLE) || (state == DONE));
    assign last    = accept && (sample_cnt == 8'(COUNT - 1));

    assign busy = (state == ACCUM);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit ACC_W of acc_sum is the carry out of the accumulator; it latches ovf.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc        <= '0;
            sample_cnt <= '0;
            ovf        <= 1'b0;
        end else if (accept) begin
            acc        <= acc_sum[ACC_W-1:0];
            sample_cnt <= sample_cnt + 8'd1;
            ovf        <= ovf | acc_sum[ACC_W];
        end
    end

`ifdef ACCUM_MAX_TRACK_EN
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            max_val <= '0;
        end else if (accept && (sample > max_val)) begin
            max_val <= sample;
        end
    end
`else
    assign max_val = '0;
`endif

endmodule

// File: tb/tb_adder_result_accum.sv
// Randomized and directed bench for adder_result_accum against a batch-level reference model.
module tb_adder_result_accum;

    localparam int N     = 4;
    localparam int COUNT = 4;
    localparam int ACC_W = 6;
`ifdef ACCUM_MAX_TRACK_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, start, in_valid, cout;
    logic [N-1:0]     sum;
    logic             busy, done, ovf;
    logic [ACC_W-1:0] acc;
    logic [7:0]       sample_cnt;
    logic [N:0]       max_val;

    always #5 clk = ~clk;

    adder_result_accum #(.N(N), .COUNT(COUNT), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .sum        (sum),
        .cout       (cout),
        .busy       (busy),
        .done       (done),
        .acc        (acc),
        .sample_cnt (sample_cnt),
        .ovf        (ovf),
        .max_val    (max_val)
    );

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    // Model: 0 idle, 1 collecting, 2 batch complete; the batch itself is the list of accepted samples.
    int m_mode = 0;
    int m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit s, input bit v, input int smp);
        if (r) begin
            m_mode = 0;
            m_q.delete();
        end else begin
            case (m_mode)
                0: if (s) begin m_mode = 1; m_q.delete(); end
                1: if (v) begin
                    m_q.push_back(smp);
                    if (m_q.size() == COUNT) m_mode = 2;
                end
                default: if (s) begin m_mode = 1; m_q.delete(); end else m_mode = 0;
            endcase
        end
    endtask

    task automatic check_model();
        int total;
        int mx;
        total = 0;
        mx = 0;
        foreach (m_q[i]) begin
            total += m_q[i];
            if (m_q[i] > mx) mx = m_q[i];
        end
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("acc", 32'(acc), 32'(total % (1 << ACC_W)));
        chk("sample_cnt", 32'(sample_cnt), 32'(m_q.size()));
        chk("ovf", 32'(ovf), 32'(total >= (1 << ACC_W)));
        chk("max_val", 32'(max_val), MAX_EN ? 32'(mx) : 32'd0);
    endtask

    task automatic step(input bit r, input bit s, input bit v, input int smp);
        logic [N:0] smp_w;
        smp_w    = (N+1)'(smp);
        reset    = r;
        start    = s;
        in_valid = v;
        cout     = smp_w[N];
        sum      = smp_w[N-1:0];
        @(posedge clk);
        model_update(r, s, v, smp);
        #1;
        if (done === 1'b1) done_seen++;
        check_model();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; cout = 1'b0; sum = '0;

        // Reset held mid-batch for two cycles
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 3);
        step(0, 0, 1, 5);
        step(1, 1, 1, 7);
        step(1, 0, 1, 7);
        chk("reset_acc", 32'(acc), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Basic batch 1,2,3,4 with idle gaps
        step(0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 1, k);
            if (k < 4) step(0, 0, 0, 0);
        end
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_acc", 32'(acc), 32'd10);
        chk("basic_cnt", 32'(sample_cnt), 32'd4);
        chk("basic_ovf", 32'(ovf), 32'd0);
        chk("basic_max", 32'(max_val), MAX_EN ? 32'd4 : 32'd0);
        step(0, 0, 0, 0);
        chk("basic_done_drop", 32'(done), 32'd0);
        chk("basic_hold_acc", 32'(acc), 32'd10);

        // Overflow batch, then back-to-back restart from DONE
        step(0, 1, 0, 0);
        step(0, 0, 1, 8);
        step(0, 0, 1, 15);
        step(0, 0, 1, 16);
        step(0, 0, 1, 31);
        chk("ovf_acc", 32'(acc), 32'd6);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_max", 32'(max_val), MAX_EN ? 32'd31 : 32'd0);
        step(0, 1, 1, 9);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_acc", 32'(acc), 32'd0);
        chk("b2b_ovf", 32'(ovf), 32'd0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 1);
        chk("b2b_acc4", 32'(acc), 32'd4);

        // Ignored inputs: in_valid in DONE/IDLE, start during ACCUM
        step(0, 0, 1, 7);
        step(0, 0, 1, 7);
        step(0, 0, 1, 7);
        chk("idle_hold_acc", 32'(acc), 32'd4);
        chk("idle_hold_cnt", 32'(sample_cnt), 32'd4);
        step(0, 1, 0, 0);
        step(0, 0, 1, 2);
        step(0, 1, 1, 3);
        chk("restart_ignored_cnt", 32'(sample_cnt), 32'd2);
        chk("restart_ignored_acc", 32'(acc), 32'd5);
        step(0, 0, 1, 4);
        step(0, 0, 1, 5);
        chk("ign_final_acc", 32'(acc), 32'd14);
        step(0, 0, 1, 6);

        // Abort after two samples of 5, then start with coincident in_valid
        step(0, 1, 0, 0);
        step(0, 0, 1, 5);
        step(0, 0, 1, 5);
        step(1, 0, 0, 0);
        chk("abort_acc", 32'(acc), 32'd0);
        done_seen = 0;
        step(0, 1, 1, 2);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("abort_final_acc", 32'(acc), 32'd8);
        chk("abort_done_pulses", 32'(done_seen), 32'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
